// File: rtl/sram_fetch_pkg.sv
// Shared types and constants for the SRAM pixel fetcher.
// Optional build macro FETCH_OVERRUN_EN is consumed by sram_pixel_fetcher only.
package sram_fetch_pkg;

    localparam int PIX_W  = 24;
    localparam int WORD_W = 16;

    // word_sel bit appended below the pixel address on sram_addr
    localparam logic WORD_LO = 1'b0;
    localparam logic WORD_HI = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        RD_LO,
        WAIT_LO,
        RD_HI,
        WAIT_HI,
        RD_DONE,
        WR_LO,
        WR_HI,
        WR_DONE
    } state_t;

endpackage

// File: rtl/sram_pixel_fetcher_if.sv
// External asynchronous SRAM bus: the fetcher is master, the memory is slave.
interface sram_pixel_fetcher_if
    import sram_fetch_pkg::*;
#(
    parameter int ADDR_W = 20
);
    logic [ADDR_W:0]   sram_addr;
    logic [WORD_W-1:0] sram_wdata;
    logic [WORD_W-1:0] sram_rdata;
    logic              sram_oe;
    logic              sram_we;

    modport master (
        output sram_addr,
        output sram_wdata,
        output sram_oe,
        output sram_we,
        input  sram_rdata
    );

    modport slave (
        input  sram_addr,
        input  sram_wdata,
        input  sram_oe,
        input  sram_we,
        output sram_rdata
    );
endinterface

// File: rtl/sram_lat_counter.sv
// Down-counter loaded with LAT-1; expired marks the last wait cycle before sampling.
module sram_lat_counter #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic s_rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            cnt <= 2'd0;
        end else if (load) begin
            cnt <= 2'(LAT - 1);
        end else if (en && cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end
    end

    assign expired = (cnt == 2'd1);
endmodule

// File: rtl/sram_pixel_fetcher.sv
// Serves 24-bit pixel reads/writes from a 16-bit async SRAM (two words per pixel).
// Build macro FETCH_OVERRUN_EN adds the sticky rd_overrun output.
module sram_pixel_fetcher
    import sram_fetch_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int SRAM_LAT = 2
) (
    input  logic              clk,
    input  logic              s_rst,
    input  logic              read_request,
    input  logic [ADDR_W-1:0] address_line,
    output logic [PIX_W-1:0]  data_line,
    output logic              data_ready,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ack,
    input  logic              wr_frame_end,
    output logic              frame_done,
    sram_pixel_fetcher_if.master sram,
`ifdef FETCH_OVERRUN_EN
    output logic              rd_overrun,
`endif
    output state_t            fsm_state
);
    // Handshakes: read_request is a one-cycle strobe with no backpressure (newest
    // address wins); wr_req is a level held with stable wr_addr/wr_data until the
    // one-cycle wr_ack; data_ready and frame_done are one-cycle pulses.
    state_t              state, next_state;
    logic                rd_pend, fe_pend;
    logic [ADDR_W-1:0]   rd_addr, cur_addr;
    logic [WORD_W-1:0]   lo_word;
    logic [7:0]          hi_byte;
    logic                lat_expired, lo_cap, hi_cap;
    logic                unused_rdata_hi;

    sram_lat_counter #(.LAT(SRAM_LAT)) u_lat (
        .clk     (clk),
        .s_rst   (s_rst),
        .load    (state == RD_LO || state == RD_HI),
        .en      (state == WAIT_LO || state == WAIT_HI),
        .expired (lat_expired)
    );

    // With SRAM_LAT == 1 the wait states are skipped and data is sampled leaving RD_x.
    assign lo_cap = (state == RD_LO && SRAM_LAT == 1) || (state == WAIT_LO && lat_expired);
    assign hi_cap = (state == RD_HI && SRAM_LAT == 1) || (state == WAIT_HI && lat_expired);
    assign unused_rdata_hi = ^sram.sram_rdata[15:8];
    assign fsm_state = state;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                // a strobe arriving this cycle becomes rd_pend next cycle and still wins
                if (rd_pend)                     next_state = RD_LO;
                else if (wr_req && !read_request) next_state = WR_LO;
            end
            RD_LO:   next_state = (SRAM_LAT == 1) ? RD_HI : WAIT_LO;
            WAIT_LO: if (lat_expired) next_state = RD_HI;
            RD_HI:   next_state = (SRAM_LAT == 1) ? RD_DONE : WAIT_HI;
            WAIT_HI: if (lat_expired) next_state = RD_DONE;
            RD_DONE: begin
                if (read_request) next_state = RD_LO;
                else if (wr_req)  next_state = WR_LO;
                else              next_state = IDLE;
            end
            WR_LO:   next_state = WR_HI;
            WR_HI:   next_state = WR_DONE;
            WR_DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sram.sram_addr  = '0;
        sram.sram_wdata = '0;
        sram.sram_oe    = 1'b0;
        sram.sram_we    = 1'b0;
        wr_ack          = 1'b0;
        if (!s_rst) begin
            unique case (state)
                RD_LO:   begin sram.sram_addr = {cur_addr, WORD_LO}; sram.sram_oe = 1'b1; end
                WAIT_LO: sram.sram_addr = {cur_addr, WORD_LO};
                RD_HI:   begin sram.sram_addr = {cur_addr, WORD_HI}; sram.sram_oe = 1'b1; end
                WAIT_HI: sram.sram_addr = {cur_addr, WORD_HI};
                WR_LO: begin
                    sram.sram_addr  = {wr_addr, WORD_LO};
                    sram.sram_wdata = wr_data[15:0];
                    sram.sram_we    = 1'b1;
                end
                WR_HI: begin
                    sram.sram_addr  = {wr_addr, WORD_HI};
                    sram.sram_wdata = {8'h00, wr_data[23:16]};
                    sram.sram_we    = 1'b1;
                end
                WR_DONE: wr_ack = 1'b1;
                default: ;
            endcase
        end
    end

    assign frame_done = fe_pend && (state == IDLE) && !wr_req && !s_rst;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state      <= IDLE;
            rd_pend    <= 1'b0;
            rd_addr    <= '0;
            cur_addr   <= '0;
            lo_word    <= '0;
            hi_byte    <= '0;
            data_line  <= '0;
            data_ready <= 1'b0;
            fe_pend    <= 1'b0;
        end else begin
            state      <= next_state;
            data_ready <= 1'b0;
            if (read_request) begin
                rd_pend <= 1'b1;
                rd_addr <= address_line;
            end else if (state == RD_DONE) begin
                rd_pend <= 1'b0;
            end
            if (next_state == RD_LO && state != RD_LO)
                cur_addr <= read_request ? address_line : rd_addr;
            if (lo_cap) lo_word <= sram.sram_rdata;
            if (hi_cap) hi_byte <= sram.sram_rdata[7:0];
            if (state == RD_DONE) begin
                data_line  <= {hi_byte, lo_word};
                data_ready <= 1'b1;
            end
            fe_pend <= frame_done ? 1'b0 : (fe_pend | wr_frame_end);
        end
    end

`ifdef FETCH_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (s_rst)
            rd_overrun <= 1'b0;
        else if (read_request && rd_pend && state != RD_DONE)
            rd_overrun <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sram_pixel_fetcher.sv
// Self-checking bench for sram_pixel_fetcher with a behavioural SRAM (SRAM_LAT = 2).
module tb_sram_pixel_fetcher;
    import sram_fetch_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        s_rst = 1'b1;
    logic        read_request = 1'b0;
    logic [19:0] address_line = '0;
    logic [23:0] data_line;
    logic        data_ready;
    logic        wr_req = 1'b0;
    logic [19:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        wr_ack;
    logic        wr_frame_end = 1'b0;
    logic        frame_done;
    state_t      fsm_state;
`ifdef FETCH_OVERRUN_EN
    logic        rd_overrun;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [23:0] exp_q[$];
    logic [36:0] wr_exp_q[$];

    sram_pixel_fetcher_if #(.ADDR_W(20)) sif ();

    sram_pixel_fetcher #(.ADDR_W(20), .SRAM_LAT(LAT)) dut (
        .clk          (clk),
        .s_rst        (s_rst),
        .read_request (read_request),
        .address_line (address_line),
        .data_line    (data_line),
        .data_ready   (data_ready),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .wr_frame_end (wr_frame_end),
        .frame_done   (frame_done),
        .sram         (sif),
`ifdef FETCH_OVERRUN_EN
        .rd_overrun   (rd_overrun),
`endif
        .fsm_state    (fsm_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural SRAM: data for an oe cycle is presented LAT-1 cycles later
    logic [15:0] mem [0:127];
    logic [15:0] rd_q = 16'hDEAD;
    logic        pl_en = 1'b0;
    logic [6:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (sif.sram_we) mem[sif.sram_addr[6:0]] <= sif.sram_wdata;
        rd_q <= sif.sram_oe ? mem[sif.sram_addr[6:0]] : 16'hDEAD;
    end
    assign sif.sram_rdata = rd_q;

    // scoreboard monitor
    always @(negedge clk) begin
        if (!s_rst) begin
            if (data_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_data: unexpected data_ready, data_line=%h", data_line);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    if (data_line !== e) begin
                        errors++;
                        $display("FAIL read_data: got %h expected %h", data_line, e);
                    end
                end
            end
            if (sif.sram_we) begin
                checks++;
                if (wr_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_write: unexpected write addr=%h data=%h", sif.sram_addr, sif.sram_wdata);
                end else begin
                    logic [36:0] w;
                    w = wr_exp_q.pop_front();
                    if ({sif.sram_addr, sif.sram_wdata} !== w) begin
                        errors++;
                        $display("FAIL sram_write: got addr=%h data=%h expected addr=%h data=%h",
                                 sif.sram_addr, sif.sram_wdata, w[36:16], w[15:0]);
                    end
                end
            end
            if (sif.sram_we || sif.sram_oe) begin
                checks++;
                if (sif.sram_we && sif.sram_oe) begin
                    errors++;
                    $display("FAIL strobe_excl: oe=%b we=%b expected not both", sif.sram_oe, sif.sram_we);
                end
            end
        end
    end

    function automatic logic [36:0] wr_word(input logic [19:0] pix, input logic sel, input logic [15:0] d);
        return {pix, sel, d};
    endfunction

    // driver tasks
    task automatic preload(input logic [6:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_read(input logic [19:0] a, input logic [23:0] e);
        int t0;
        int lat;
        bit got;
        @(posedge clk); #1;
        read_request = 1'b1; address_line = a; t0 = cyc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        read_request = 1'b0;
        got = 1'b0;
        lat = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (data_ready) begin got = 1'b1; lat = cyc - t0; end
        end
        checks++;
        if (lat != 2 * LAT + 3) begin
            errors++;
            $display("FAIL read_latency: got %0d expected %0d (addr %h)", lat, 2 * LAT + 3, a);
        end
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b0 || data_line !== e) begin
            errors++;
            $display("FAIL read_hold: data_ready=%b data_line=%h expected 0/%h", data_ready, data_line, e);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 s_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (data_line !== 24'h0 || data_ready !== 1'b0 || wr_ack !== 1'b0 || frame_done !== 1'b0 ||
            sif.sram_oe !== 1'b0 || sif.sram_we !== 1'b0 || sif.sram_addr !== 21'h0 ||
            sif.sram_wdata !== 16'h0 || fsm_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: dl=%h dr=%b ack=%b fd=%b oe=%b we=%b addr=%h st=%0d expected all 0/IDLE",
                     data_line, data_ready, wr_ack, frame_done, sif.sram_oe, sif.sram_we, sif.sram_addr, fsm_state);
        end
    endtask

    task automatic test_read;
        do_read(20'h00010, 24'h113344);
`ifdef FETCH_OVERRUN_EN
        checks++;
        if (rd_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_quiet: got %b expected 0", rd_overrun);
        end
`endif
    endtask

    task automatic test_write;
        int ack_c;
        wr_exp_q.push_back(wr_word(20'h5, 1'b0, 16'hCDEF));
        wr_exp_q.push_back(wr_word(20'h5, 1'b1, 16'h00AB));
        ack_c = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin wr_req = 1'b1; wr_addr = 20'h5; wr_data = 24'hABCDEF; end
            if (ack_c >= 0) wr_req = 1'b0;
            @(negedge clk);
            if (wr_ack && ack_c < 0) ack_c = i;
        end
        checks++;
        if (ack_c != 3) begin
            errors++;
            $display("FAIL write_ack: got cycle %0d expected 3", ack_c);
        end
        do_read(20'h5, 24'hABCDEF);
    endtask

    task automatic test_arbitration;
        int rd_c, we_c, ack_c;
        exp_q.push_back(24'h113344);
        wr_exp_q.push_back(wr_word(20'h7, 1'b0, 16'h3456));
        wr_exp_q.push_back(wr_word(20'h7, 1'b1, 16'h0012));
        rd_c = -1; we_c = -1; ack_c = -1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                read_request = 1'b1; address_line = 20'h10;
                wr_req = 1'b1; wr_addr = 20'h7; wr_data = 24'h123456;
            end else begin
                read_request = 1'b0;
            end
            if (ack_c >= 0) wr_req = 1'b0;
            @(negedge clk);
            if (data_ready && rd_c < 0) rd_c = i;
            if (sif.sram_we && we_c < 0) we_c = i;
            if (wr_ack && ack_c < 0) ack_c = i;
        end
        checks++;
        if (rd_c != 7 || we_c != 7 || ack_c != 9) begin
            errors++;
            $display("FAIL arbitration: ready@%0d we@%0d ack@%0d expected 7/7/9", rd_c, we_c, ack_c);
        end
    endtask

    task automatic test_overrun;
        int rd_c, ack_c, dr_n;
        exp_q.push_back(24'hCABEEF);
        wr_exp_q.push_back(wr_word(20'h9, 1'b0, 16'h0F0F));
        wr_exp_q.push_back(wr_word(20'h9, 1'b1, 16'h000F));
        rd_c = -1; ack_c = -1; dr_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin wr_req = 1'b1; wr_addr = 20'h9; wr_data = 24'h0F0F0F; end
            read_request = (i == 1 || i == 2);
            if (i == 1) address_line = 20'h1;
            if (i == 2) address_line = 20'h2;
            if (ack_c >= 0) wr_req = 1'b0;
            @(negedge clk);
            if (wr_ack && ack_c < 0) ack_c = i;
            if (data_ready) begin dr_n++; if (rd_c < 0) rd_c = i; end
        end
        checks++;
        if (ack_c != 3 || rd_c != 10 || dr_n != 1) begin
            errors++;
            $display("FAIL overwrite: ack@%0d ready@%0d pulses=%0d expected 3/10/1", ack_c, rd_c, dr_n);
        end
`ifdef FETCH_OVERRUN_EN
        checks++;
        if (rd_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: got %b expected 1", rd_overrun);
        end
`endif
    endtask

    task automatic test_frame_end;
        int ack_c, fd_c, fd_n;
        state_t fd_st;
        wr_exp_q.push_back(wr_word(20'hC, 1'b0, 16'h5566));
        wr_exp_q.push_back(wr_word(20'hC, 1'b1, 16'h0044));
        ack_c = -1; fd_c = -1; fd_n = 0; fd_st = WR_DONE;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin wr_req = 1'b1; wr_addr = 20'hC; wr_data = 24'h445566; end
            wr_frame_end = (i == 1 || i == 2);
            if (ack_c >= 0) wr_req = 1'b0;
            @(negedge clk);
            if (wr_ack && ack_c < 0) ack_c = i;
            if (frame_done) begin fd_n++; fd_c = i; fd_st = fsm_state; end
        end
        checks++;
        if (ack_c != 3 || fd_c != ack_c + 1 || fd_n != 1 || fd_st !== IDLE) begin
            errors++;
            $display("FAIL frame_done: ack@%0d done@%0d pulses=%0d state=%0d expected 3/4/1/IDLE",
                     ack_c, fd_c, fd_n, fd_st);
        end
    endtask

    task automatic test_reset_mid;
        int dr_n;
        dr_n = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            read_request = (i == 0);
            if (i == 0) address_line = 20'h10;
            if (i == 5) s_rst = 1'b1;
            if (i == 6) s_rst = 1'b0;
            @(negedge clk);
            if (data_ready) dr_n++;
            if (i == 5) begin
                checks++;
                if (fsm_state !== WAIT_HI || sif.sram_addr !== 21'h0 || sif.sram_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_abort: state=%0d addr=%h oe=%b expected WAIT_HI/0/0",
                             fsm_state, sif.sram_addr, sif.sram_oe);
                end
            end
            if (i == 6) begin
                checks++;
                if (data_line !== 24'h0 || data_ready !== 1'b0 || wr_ack !== 1'b0 || frame_done !== 1'b0 ||
                    sif.sram_oe !== 1'b0 || sif.sram_we !== 1'b0 || sif.sram_addr !== 21'h0 ||
                    fsm_state !== IDLE) begin
                    errors++;
                    $display("FAIL reset_after: dl=%h dr=%b oe=%b we=%b addr=%h st=%0d expected 0/IDLE",
                             data_line, data_ready, sif.sram_oe, sif.sram_we, sif.sram_addr, fsm_state);
                end
`ifdef FETCH_OVERRUN_EN
                checks++;
                if (rd_overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL overrun_reset: got %b expected 0", rd_overrun);
                end
`endif
            end
        end
        checks++;
        if (dr_n != 0) begin
            errors++;
            $display("FAIL reset_no_ready: got %0d pulses expected 0", dr_n);
        end
        do_read(20'h5, 24'hABCDEF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preload(7'h20, 16'h3344);
        preload(7'h21, 16'h0011);
        preload(7'h02, 16'h1111);
        preload(7'h03, 16'h0022);
        preload(7'h04, 16'hBEEF);
        preload(7'h05, 16'hFFCA);
        test_reset();
        test_read();
        test_write();
        test_arbitration();
        test_overrun();
        test_frame_end();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || wr_exp_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: reads left %0d writes left %0d expected 0/0",
                     exp_q.size(), wr_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_pixel_fetcher.md
Name: sram_pixel_fetcher

Overview:
Memory-side stage directly upstream of the HDMI transmitter. It serves the transmitter's pixel read requests (20-bit pixel address in, 24-bit RGB out) from an external 16-bit asynchronous SRAM, where each pixel occupies two words. It also accepts pixel writes from the image-producing side, arbitrating them against reads. It generates the frame_done indication the transmitter consumes.

Parameters:
ADDR_W, 20, pixel address width; SRAM word address is ADDR_W+1.
SRAM_LAT, 2, cycles from address/oe issue to the clock edge at which sram_rdata is sampled; legal 1..4.

Ports:
clk  in  1  system clock
s_rst  in  1  synchronous active-high reset
read_request  in  1  one-cycle read strobe from transmitter
address_line  in  ADDR_W  pixel address, valid with read_request
data_line  out  24  assembled pixel {R,G,B}; held between updates
data_ready  out  1  one-cycle pulse: data_line updated
wr_req  in  1  write request, held high until wr_ack
wr_addr  in  ADDR_W  write pixel address, stable while wr_req
wr_data  in  24  write pixel, stable while wr_req
wr_ack  out  1  one-cycle pulse: both words written
wr_frame_end  in  1  one-cycle strobe: last pixel of frame has been requested
frame_done  out  1  one-cycle pulse to transmitter
sram_addr  out  ADDR_W+1  {pixel_addr, word_sel}; word_sel 0 = low word
sram_wdata  out  16  write data
sram_rdata  in  16  read data
sram_oe  out  1  read strobe, active-high
sram_we  out  1  write strobe, active-high

Behaviour:
- Single clock domain; s_rst synchronous and active-high. Reset: all outputs 0, data_line = 24'h0, FSM = IDLE, pending flags cleared.
- FSM states: IDLE, RD_LO, WAIT_LO, RD_HI, WAIT_HI, RD_DONE, WR_LO, WR_HI, WR_DONE.
- Pending read: a read_request in any state sets rd_pend and latches address_line. A request already pending is overwritten by a newer one, so the newer address wins.
- IDLE arbitration: rd_pend takes priority over wr_req. A started transaction always completes and is never pre-empted.
- Read: RD_LO drives sram_addr={a,0} and sram_oe=1 for 1 cycle. WAIT_LO lasts SRAM_LAT-1 cycles, then the low word is captured into data_line[15:0] staging. RD_HI/WAIT_HI repeat this with {a,1}, capturing sram_rdata[7:0] into [23:16]; sram_rdata[15:8] is ignored. In RD_DONE, data_line updates atomically (all 24 bits in one cycle), data_ready pulses, and rd_pend clears unless a new request arrived in this same cycle.
- Read latency: request in cycle 0 gives data_ready in cycle 2*SRAM_LAT+3. For SRAM_LAT=2 this is cycle 7.
- Write: WR_LO drives {wr_addr,0}, sram_wdata=wr_data[15:0], sram_we=1. WR_HI drives {wr_addr,1}, sram_wdata={8'h00,wr_data[23:16]}, sram_we=1. WR_DONE pulses wr_ack. sram_we and sram_oe are never high together.
- Frame end: wr_frame_end sets fe_pend. frame_done pulses in the first cycle with fe_pend=1, FSM in IDLE and wr_req=0; fe_pend then clears. If a write is still being requested, frame_done waits for its wr_ack. A second wr_frame_end while fe_pend is set is absorbed and yields one pulse.
- Address wrap: none is needed; the full pixel address goes straight to SRAM.
- s_rst mid-transaction: the access aborts at once, strobes drop the same cycle, no data_ready/wr_ack is produced, and pending flags are lost.

Optional Feature:
FETCH_OVERRUN_EN. When defined: adds output rd_overrun (1 bit), a sticky flag set when read_request arrives while rd_pend=1 and the arriving request is not the one being cleared in RD_DONE; cleared only by s_rst. When undefined: the port is absent and overwrite happens silently.

Decomposition:
- Package sram_fetch_pkg holds: the state enum, PIX_W=24, WORD_W=16, and localparams for word_sel encoding.
- One natural sub-module, sram_lat_counter: a down-counter loaded with SRAM_LAT-1 that flags expiry. It is reused by both WAIT states.

Test Plan:
- Reset, then a read at address 20'h00010 with SRAM model words 0x3344 @{10,0} and 0x0011 @{10,1}, SRAM_LAT=2 -> data_ready at cycle 7, data_line=24'h113344, exactly one pulse.
- wr_req at addr 5 with 24'hABCDEF -> sram_we pulses for {5,0}=16'hCDEF and {5,1}=16'h00AB; wr_ack 3 cycles after the request; then a read at addr 5 returns 24'hABCDEF.
- read_request and wr_req in the same IDLE cycle -> read serviced first; write starts the cycle after RD_DONE; wr_req stays held until wr_ack.
- Two read_requests (addr 1, then addr 2) during a write -> after wr_ack only addr 2 is read; one data_ready; rd_overrun=1 when FETCH_OVERRUN_EN is defined.
- wr_frame_end during a held write -> frame_done is withheld until one cycle after wr_ack and returns to IDLE; a single pulse.
- s_rst asserted in WAIT_HI -> next cycle all outputs 0, no data_ready, data_line=0; a subsequent read behaves normally.
